// File: rtl/exe_alu_stage_if.sv
// exe_alu_stage_if: ID/EXE -> EXE/MEM bundle for the ARM execute stage.
// The master (decode side / bench) drives the instruction slot and the
// stall/redirect controls; the slave (exe_alu_stage) returns the registered
// EXE/MEM contents, the NZCV status register and the retired-op counter.
interface exe_alu_stage_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic             freeze;
    logic             flush;
    logic [3:0]       exe_cmd;
    logic             s_bit;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] st_val;
    logic [3:0]       dest;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] st_val_out;
    logic [3:0]       dest_out;
    logic             wb_en_out;
    logic             mem_r_en_out;
    logic             mem_w_en_out;
    logic             valid_out;
    logic [3:0]       status;
    logic [WIDTH-1:0] perf_cnt;

    modport master (
        output valid_in, freeze, flush, exe_cmd, s_bit, wb_en, mem_r_en,
               mem_w_en, val1, val2, st_val, dest,
        input  alu_res, st_val_out, dest_out, wb_en_out, mem_r_en_out,
               mem_w_en_out, valid_out, status, perf_cnt
    );

    modport slave (
        input  valid_in, freeze, flush, exe_cmd, s_bit, wb_en, mem_r_en,
               mem_w_en, val1, val2, st_val, dest,
        output alu_res, st_val_out, dest_out, wb_en_out, mem_r_en_out,
               mem_w_en_out, valid_out, status, perf_cnt
    );
endinterface

// File: rtl/exe_alu_stage.sv
// exe_alu_stage: execute stage of the 5-stage ARM pipeline.
// Computes the data-processing / address result from val1 and val2, keeps
// the NZCV status register and latches the EXE/MEM pipeline register with
// freeze (stall) and flush (redirect) control. Flush beats freeze; a bubble
// (valid_in=0) clears the slot unless the stage is frozen.
// Optional feature macro: EXE_PERF_CNT_EN enables the 32-bit retired-op
// counter on perf_cnt; without it perf_cnt is tied to zero.
module exe_alu_stage #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    exe_alu_stage_if.slave    bus
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [WIDTH-1:0] r_alu_res;
    logic [WIDTH-1:0] r_st_val;
    logic [3:0]       r_dest;
    logic             r_wb_en;
    logic             r_mem_r_en;
    logic             r_mem_w_en;
    logic             r_valid;
    logic [3:0]       r_status;

    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_res;
    logic             w_known;
    logic             w_c;
    logic             w_v;
    logic             w_n;
    logic             w_z;
    logic             w_c_in;
    logic             w_status_we;
    logic [3:0]       w_status_nxt;

    // Current carry feeds ADC/SBC; it is the registered value, so a
    // back-to-back S-instruction sees the C written at the previous edge.
    assign w_c_in = r_status[1];

    // ALU: 33-bit arithmetic for carry/borrow, logic ops keep C and V.
    always_comb begin
        w_wide  = {(WIDTH+1){1'b0}};
        w_res   = {WIDTH{1'b0}};
        w_known = 1'b0;
        w_c     = r_status[1];
        w_v     = r_status[0];
        case (bus.exe_cmd)
            CMD_MOV: begin
                w_res   = bus.val2;
                w_known = 1'b1;
            end
            CMD_MVN: begin
                w_res   = ~bus.val2;
                w_known = 1'b1;
            end
            CMD_ADD, CMD_ADC: begin
                w_wide  = {1'b0, bus.val1} + {1'b0, bus.val2}
                        + {{WIDTH{1'b0}}, (bus.exe_cmd == CMD_ADC) & w_c_in};
                w_res   = w_wide[WIDTH-1:0];
                w_known = 1'b1;
                w_c     = w_wide[WIDTH];
                w_v     = (bus.val1[WIDTH-1] == bus.val2[WIDTH-1]) &&
                          (w_wide[WIDTH-1] != bus.val1[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                // Bit 32 of the 33-bit difference is the borrow; C = !borrow.
                w_wide  = {1'b0, bus.val1} - {1'b0, bus.val2}
                        - {{WIDTH{1'b0}}, (bus.exe_cmd == CMD_SBC) & ~w_c_in};
                w_res   = w_wide[WIDTH-1:0];
                w_known = 1'b1;
                w_c     = ~w_wide[WIDTH];
                w_v     = (bus.val1[WIDTH-1] != bus.val2[WIDTH-1]) &&
                          (w_wide[WIDTH-1] != bus.val1[WIDTH-1]);
            end
            CMD_AND: begin
                w_res   = bus.val1 & bus.val2;
                w_known = 1'b1;
            end
            CMD_ORR: begin
                w_res   = bus.val1 | bus.val2;
                w_known = 1'b1;
            end
            CMD_EOR: begin
                w_res   = bus.val1 ^ bus.val2;
                w_known = 1'b1;
            end
            default: begin
                w_res   = {WIDTH{1'b0}};
                w_known = 1'b0;
            end
        endcase
    end

    assign w_n = w_res[WIDTH-1];
    assign w_z = (w_res == {WIDTH{1'b0}});
    assign w_status_we = bus.valid_in & bus.s_bit & ~bus.freeze & ~bus.flush;

    // Next NZCV: unknown opcodes leave every flag untouched.
    always_comb begin
        w_status_nxt = r_status;
        if (w_status_we && w_known) begin
            w_status_nxt = {w_n, w_z, w_c, w_v};
        end else begin
            w_status_nxt = r_status;
        end
    end

    // EXE/MEM pipeline register: flush > freeze > bubble > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_res  <= {WIDTH{1'b0}};
            r_st_val   <= {WIDTH{1'b0}};
            r_dest     <= 4'b0000;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_valid    <= 1'b0;
        end else if (bus.flush || (!bus.freeze && !bus.valid_in)) begin
            r_alu_res  <= {WIDTH{1'b0}};
            r_st_val   <= {WIDTH{1'b0}};
            r_dest     <= 4'b0000;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_valid    <= 1'b0;
        end else if (!bus.freeze) begin
            r_alu_res  <= w_res;
            r_st_val   <= bus.st_val;
            r_dest     <= bus.dest;
            r_wb_en    <= bus.wb_en;
            r_mem_r_en <= bus.mem_r_en;
            r_mem_w_en <= bus.mem_w_en;
            r_valid    <= 1'b1;
        end else begin
            r_alu_res  <= r_alu_res;
            r_st_val   <= r_st_val;
            r_dest     <= r_dest;
            r_wb_en    <= r_wb_en;
            r_mem_r_en <= r_mem_r_en;
            r_mem_w_en <= r_mem_w_en;
            r_valid    <= r_valid;
        end
    end

    // NZCV status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 4'b0000;
        end else begin
            r_status <= w_status_nxt;
        end
    end

    assign bus.alu_res      = r_alu_res;
    assign bus.st_val_out   = r_st_val;
    assign bus.dest_out     = r_dest;
    assign bus.wb_en_out    = r_wb_en;
    assign bus.mem_r_en_out = r_mem_r_en;
    assign bus.mem_w_en_out = r_mem_w_en;
    assign bus.valid_out    = r_valid;
    assign bus.status       = r_status;

`ifdef EXE_PERF_CNT_EN
    logic [WIDTH-1:0] r_perf_cnt;

    // Retired-op counter: counts valid, unfrozen, unflushed slots; wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt <= {WIDTH{1'b0}};
        end else if (bus.valid_in && !bus.freeze && !bus.flush) begin
            r_perf_cnt <= r_perf_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_perf_cnt <= r_perf_cnt;
        end
    end

    assign bus.perf_cnt = r_perf_cnt;
`else
    assign bus.perf_cnt = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_exe_alu_stage.sv
// tb_exe_alu_stage: directed plus randomized checks of exe_alu_stage against
// a behavioural model working on plain integer arithmetic.
module tb_exe_alu_stage;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    exe_alu_stage_if #(.WIDTH(32)) bus ();

    exe_alu_stage #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    logic [31:0] m_alu, m_st, m_perf;
    logic [3:0]  m_dest, m_status;
    logic        m_wb, m_mr, m_mw, m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_alu = 32'd0; m_st = 32'd0; m_perf = 32'd0; m_dest = 4'd0;
        m_status = 4'd0; m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_valid = 1'b0;
    endtask

    // Next state of the model for the inputs currently driven.
    task automatic model_edge();
        longint a, b, r;
        bit     cin, known, arith, is_sub, c, v;
        logic [31:0] res;
        a = longint'(bus.val1); b = longint'(bus.val2);
        cin = m_status[1]; known = 1'b1; arith = 1'b0; is_sub = 1'b0; c = 1'b0;
        case (bus.exe_cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd2: begin r = a + b; arith = 1'b1; c = (r > 64'hFFFF_FFFF); end
            4'd3: begin r = a + b + longint'(cin); arith = 1'b1; c = (r > 64'hFFFF_FFFF); end
            4'd4: begin r = a - b; arith = 1'b1; is_sub = 1'b1; c = (a >= b); end
            4'd5: begin
                r = a - b - longint'(!cin); arith = 1'b1; is_sub = 1'b1;
                c = (a >= b + longint'(!cin));
            end
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            default: begin r = 0; known = 1'b0; end
        endcase
        res = r[31:0];
        if (is_sub) v = (bus.val1[31] != bus.val2[31]) && (res[31] != bus.val1[31]);
        else        v = (bus.val1[31] == bus.val2[31]) && (res[31] != bus.val1[31]);
        if (bus.valid_in && bus.s_bit && !bus.freeze && !bus.flush && known) begin
            m_status[3] = res[31];
            m_status[2] = (res == 32'd0);
            if (arith) begin m_status[1] = c; m_status[0] = v; end
        end
`ifdef EXE_PERF_CNT_EN
        if (bus.valid_in && !bus.freeze && !bus.flush) m_perf = m_perf + 32'd1;
`endif
        if (bus.flush || (!bus.freeze && !bus.valid_in)) begin
            m_alu = 32'd0; m_st = 32'd0; m_dest = 4'd0;
            m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_valid = 1'b0;
        end else if (!bus.freeze) begin
            m_alu = res; m_st = bus.st_val; m_dest = bus.dest;
            m_wb = bus.wb_en; m_mr = bus.mem_r_en; m_mw = bus.mem_w_en; m_valid = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alu_res"},  bus.alu_res,    m_alu);
        chk({tag, ".st_val"},   bus.st_val_out, m_st);
        chk({tag, ".dest"},     {28'd0, bus.dest_out}, {28'd0, m_dest});
        chk({tag, ".ctl"},      {28'd0, bus.valid_out, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out},
                                {28'd0, m_valid, m_wb, m_mr, m_mw});
        chk({tag, ".status"},   {28'd0, bus.status}, {28'd0, m_status});
        chk({tag, ".perf_cnt"}, bus.perf_cnt,   m_perf);
    endtask

    task automatic drive(input logic [3:0] cmd, input logic s, input logic wb,
                         input logic mr, input logic mw, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] st, input logic [3:0] d);
        bus.valid_in = 1'b1; bus.freeze = 1'b0; bus.flush = 1'b0;
        bus.exe_cmd = cmd; bus.s_bit = s; bus.wb_en = wb; bus.mem_r_en = mr;
        bus.mem_w_en = mw; bus.val1 = v1; bus.val2 = v2; bus.st_val = st; bus.dest = d;
    endtask

    // One clock: update model, take the edge, compare 1 time unit later.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] perf_before;
    logic [3:0]  stat_before;

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        bus.valid_in = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;

        // ADDS overflow into the sign bit
        drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 4'd3);
        step("adds_ovf");
        chk("adds_ovf.res_const", bus.alu_res, 32'h8000_0000);
        chk("adds_ovf.nzcv_const", {28'd0, bus.status}, 32'h0000_0009);

        // Async reset mid-cycle after an ADDS is loaded
        drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h5, 4'd4);
        step("pre_rst");
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst.res_zero", bus.alu_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0005, 32'h0, 4'd1);
        step("mov_after_rst");
        chk("mov_after_rst.const", bus.alu_res, 32'h0000_0005);

        // CMP 5-5
        drive(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0, 4'd2);
        step("cmp");
        chk("cmp.nzcv_const", {28'd0, bus.status}, 32'h0000_0006);
        chk("cmp.wb_const", {31'd0, bus.wb_en_out}, 32'd0);

        // SUBS 0-1, SBCS 3-1, ADCS 1+2
        drive(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1, 32'h0, 4'd5);
        step("subs");
        chk("subs.res_const", bus.alu_res, 32'hFFFF_FFFF);
        chk("subs.nzcv_const", {28'd0, bus.status}, 32'h0000_0008);
        drive(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd1, 32'h0, 4'd6);
        step("sbc");
        chk("sbc.res_const", bus.alu_res, 32'd1);
        drive(4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 4'd7);
        step("adc");
        chk("adc.res_const", bus.alu_res, 32'd4);

        // Set C=V=1, then ANDS holds C and V
        drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 4'd8);
        step("adds_cv");
        drive(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0, 4'd9);
        step("ands");
        chk("ands.nzcv_const", {28'd0, bus.status}, 32'h0000_0007);

        // Freeze two cycles, then flush+freeze with a STR
        perf_before = bus.perf_cnt;
        stat_before = bus.status;
        drive(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'h0, 4'd10);
        bus.freeze = 1'b1;
        step("freeze1");
        step("freeze2");
        chk("freeze.perf_hold", bus.perf_cnt, perf_before);
        drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'd100, 32'd4, 32'hABCD, 4'd11);
        bus.freeze = 1'b1; bus.flush = 1'b1;
        step("flush_freeze");
        chk("flush.valid_const", {31'd0, bus.valid_out}, 32'd0);
        chk("flush.mw_const", {31'd0, bus.mem_w_en_out}, 32'd0);
        chk("flush.status_hold", {28'd0, bus.status}, {28'd0, stat_before});
        chk("flush.perf_hold", bus.perf_cnt, perf_before);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), rv(), rv(), $urandom, 4'($urandom));
            bus.valid_in = ($urandom_range(0, 7) != 0);
            bus.flush    = ($urandom_range(0, 9) == 0);
            bus.freeze   = ($urandom_range(0, 7) == 0);
            if (bus.freeze) bus.valid_in = 1'b1;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exe_alu_stage.md
# exe_alu_stage

Execute stage of the 5-stage ARM pipeline. It consumes Val1 from the register file and the shifted/rotated Val2 operand. It computes the data-processing or address result and maintains the NZCV status register. It also registers the result and the control bits into the EXE/MEM pipeline register, with freeze (hazard stall) and flush (branch redirect) support.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  ID/EXE slot holds a real instruction.
- freeze  in  1  hold the EXE/MEM register and status this cycle.
- flush  in  1  kill the instruction entering EXE/MEM this cycle.
- exe_cmd  in  4  ALU opcode.
- s_bit  in  1  update status.
- wb_en, mem_r_en, mem_w_en  in  1 each  control bits passed through.
- val1  in  32  Rn value.
- val2  in  32  shifter operand value.
- st_val  in  32  Rd value for STR.
- dest  in  4  destination register.
- alu_res  out  32  registered result or address.
- st_val_out  out  32  registered st_val.
- dest_out  out  4  registered dest.
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered control bits.
- valid_out  out  1  EXE/MEM slot valid.
- status  out  4  NZCV status register {N,Z,C,V}.
- perf_cnt  out  32  retired-op counter (see Configuration).

## Operation
- exe_cmd encoding:
  - 0001 MOV: res = val2.
  - 1001 MVN: res = ~val2.
  - 0010 ADD/LDR/STR: res = val1+val2.
  - 0011 ADC: res = val1+val2+C.
  - 0100 SUB/CMP: res = val1−val2.
  - 0101 SBC: res = val1−val2−!C.
  - 0110 AND/TST.
  - 0111 ORR.
  - 1000 EOR.
  - Any other code: res = 0, flags unchanged.
- Arithmetic is computed 33 bits wide.
  - Add: C = bit 32.
  - Sub: C = NOT borrow, so C=1 iff no borrow.
  - V (add) = (a[31]==b[31]) && (r[31]!=a[31]).
  - V (sub) = (a[31]!=b[31]) && (r[31]!=a[31]).
- N = res[31]; Z = (res==0). Logic and move ops update N and Z only; C and V are held.
- ADC and SBC use the current status C (the registered value, before this instruction's update).
- CMP and TST are issued with wb_en=0. The result is still registered but is not written back.
- Status is written only when valid_in & s_bit & !freeze & !flush.

## Timing
- Latency is 1 cycle: inputs are sampled at the rising edge, and alu_res/control/valid_out are visible after that edge. Status updates at the same edge.
- freeze=1: EXE/MEM register, status and perf_cnt all hold.
- flush=1: at the edge, valid_out, wb_en_out, mem_r_en_out and mem_w_en_out go to 0. alu_res, st_val_out and dest_out go to 0. Status is not updated.
- flush and freeze high together: flush wins.
- valid_in=0 (bubble): same as flush for outputs; status is held.
- Back-to-back S-instructions: instruction n+1's ADC/SBC sees the C written by instruction n. No internal bypass is needed, because the write completes at the same edge that latches n+1.
- Reset: asynchronous and immediate.
  - All outputs, status and perf_cnt go to 0.
  - An instruction in flight at assertion is discarded.
  - The first edge after deassertion samples normally.

## Configuration
- EXE_PERF_CNT_EN defined:
  - perf_cnt is a 32-bit counter that increments at each edge where valid_in & !freeze & !flush.
  - It wraps 0xFFFFFFFF→0 and resets to 0.
- Not defined: no counter logic; perf_cnt is tied to 0.

## Test plan
- Async reset: drive rst_n=0 between edges after loading ADDS → all outputs and status are 0 before the next edge. Deassert, issue MOV val2=0x5 → alu_res=0x5 one edge later.
- ADDS 0x7FFFFFFF+0x00000001 → alu_res=0x80000000, status=1001 (N=1, Z=0, C=0, V=1).
- CMP (exe_cmd 0100, s_bit=1, wb_en=0) 5−5 → alu_res=0, wb_en_out=0, status=0110 (Z=1, C=1).
- SUBS 0−1 → 0xFFFFFFFF, status=1000. Next cycle SBC 3−1 → 3−1−1=1. Then ADC 1+2 with C=1 → 4.
- ANDS with C=1, V=1 prior: 0xF0 & 0x0F → alu_res=0, status=0111. C and V are held.
- Freeze then flush:
  - freeze=1 for 2 cycles with ADDS presented → outputs, status and perf_cnt hold.
  - Then flush=1 with freeze=1 and STR valid → valid_out=0, mem_w_en_out=0, status unchanged.
  - With EXE_PERF_CNT_EN, perf_cnt is unchanged across both, and increments by exactly 1 per unfrozen valid instruction otherwise.
